// File: rtl/sram_defs.sv
// Shared definitions for the cache-side SRAM sequencer: state encodings,
// beat counts and SRAM pin widths.
package sram_defs;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int READ_BEATS  = 4;
    localparam int WRITE_BEATS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sram_controller_if.sv
// Cache-side request/response bundle between the cache controller (master)
// and the SRAM sequencer (slave).
interface sram_controller_if;
    import sram_defs::*;

    logic [SRAM_ADDR_W-1:0] address;
    logic [31:0]            wdata;
    logic                   r_en;
    logic                   w_en;
    logic [63:0]            rdata;
    logic                   ready;

    modport master (output address, wdata, r_en, w_en, input rdata, ready);
    modport slave  (input address, wdata, r_en, w_en, output rdata, ready);

endinterface

// File: rtl/sram_beat_counter.sv
// Hold/beat counter: each beat lasts HOLD_CYCLES clocks; both counts clear
// whenever no access is running.
module sram_beat_counter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] last_idx,
    output logic [1:0] beat,
    output logic       beat_end,
    output logic       last_beat
);
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        beat_q, beat_d;

    assign beat_end  = run && (hold_q == HOLD_LAST);
    assign last_beat = (beat_q == last_idx);
    assign beat      = beat_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hold_d = hold_q + 1'b1;
        beat_d = beat_q;
        if (!run) begin
            hold_d = '0;
            beat_d = '0;
        end else if (beat_end) begin
            hold_d = '0;
            beat_d = beat_q + 2'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            beat_q <= '0;
        end else begin
            hold_q <= hold_d;
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Sequences one cache request into halfword beats on an asynchronous 16-bit
// SRAM: 4-beat line reads and 2-beat word writes, with registered pin outputs.
module sram_controller
    import sram_defs::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       cache,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);
    state_e                 state_q, state_d;
    logic [15:0]            addr_q, addr_d;         // halfword-pair address, byte addr[17:2]
    logic [31:0]            wdata_q, wdata_d;
    logic [63:0]            shadow_q, shadow_d;
    logic [63:0]            rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   we_n_q, we_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;

    logic       run, beat_end, last_beat;
    logic [1:0] beat, last_idx, nxt_beat;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^cache.address[1:0];

    assign run      = (state_q == READ) || (state_q == WRITE);
    assign last_idx = (state_q == READ) ? 2'(READ_BEATS - 1) : 2'(WRITE_BEATS - 1);

    sram_beat_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .last_idx  (last_idx),
        .beat      (beat),
        .beat_end  (beat_end),
        .last_beat (last_beat)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shadow_d    = shadow_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        nxt_beat    = 2'd0;

        unique case (state_q)
            IDLE: begin
                if (cache.w_en) begin
                    state_d = WRITE;
                    addr_d  = cache.address[17:2];
                    wdata_d = cache.wdata;
                end else if (cache.r_en) begin
                    state_d = READ;
                    addr_d  = cache.address[17:2];
                end
            end
            READ: begin
                if (beat_end) begin
                    shadow_d[{beat, 4'b0000} +: 16] = SRAM_DQ;
                    if (last_beat) begin
                        state_d = DONE;
                        rdata_d = shadow_d;
                    end
                end
            end
            WRITE: begin
                if (beat_end && last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are computed for the coming cycle so they leave straight from flops.
        if (run) nxt_beat = beat_end ? beat + 2'd1 : beat;

        unique case (state_d)
            READ: sram_addr_d = {1'b0, addr_d[15:1], nxt_beat};
            WRITE: begin
                sram_addr_d = {1'b0, addr_d, nxt_beat[0]};
                we_n_d      = 1'b0;
                dq_oe_d     = 1'b1;
                dq_out_d    = nxt_beat[0] ? wdata_d[31:16] : wdata_d[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            // NOTE: the read shadow is reset too, so a line aborted by reset never leaks into rdata.
            shadow_q    <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign cache.rdata = rdata_q;
    assign cache.ready = ((state_q == IDLE) && !cache.r_en && !cache.w_en) || (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model: halfwords
// 0x80/0x81 are fixed, 0x82/0x83 store writes, every other address reads 16'hA5C3.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem [4];

    sram_controller_if bus ();

    sram_controller #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cache     (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_rd(input logic [17:0] a);
        if (a[17:2] != 16'h0020) return 16'hA5C3;
        case (a[1:0])
            2'd0:    return 16'h1111;
            2'd1:    return 16'h2222;
            default: return mem[a[1:0]];
        endcase
    endfunction

    assign sram_dq = sram_we_n ? model_rd(sram_addr) : 16'bz;

    always @(posedge clk)
        if (!sram_we_n && sram_addr[17:2] == 16'h0020) mem[sram_addr[1:0]] <= sram_dq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.address  = '0;
        bus.wdata    = '0;
        bus.r_en     = 1'b0;
        bus.w_en     = 1'b0;
        repeat (2) tick();

        // Reset state, no request
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_we_n", 64'(sram_we_n), 64'd1);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_dq_released", 64'(sram_dq), 64'hA5C3);
        check("rst_tied", 64'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(bus.ready), 64'd1);

        // Word write 0xDEADBEEF to byte address 0x104
        bus.address = 18'h00104;
        bus.wdata   = 32'hDEADBEEF;
        bus.w_en    = 1'b1;
        #1 check("wr_c0_ready", 64'(bus.ready), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                check($sformatf("wr_c%0d_we_n", c), 64'(sram_we_n), 64'd0);
                check($sformatf("wr_c%0d_ready", c), 64'(bus.ready), 64'd0);
                check($sformatf("wr_c%0d_addr", c), 64'(sram_addr), (c <= 2) ? 64'h82 : 64'h83);
                check($sformatf("wr_c%0d_dq", c), 64'(sram_dq), (c <= 2) ? 64'hBEEF : 64'hDEAD);
            end
        end
        check("wr_c5_ready", 64'(bus.ready), 64'd1);
        check("wr_c5_we_n", 64'(sram_we_n), 64'd1);
        check("wr_c5_rdata", bus.rdata, 64'd0);
        bus.w_en = 1'b0;
        tick();
        check("wr_idle_ready", 64'(bus.ready), 64'd1);

        // Line read of byte address 0x104
        bus.r_en = 1'b1;
        #1 check("rd_c0_ready", 64'(bus.ready), 64'd0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 8) begin
                check($sformatf("rd_c%0d_addr", c), 64'(sram_addr), 64'h80 + 64'((c - 1) / 2));
                check($sformatf("rd_c%0d_ready", c), 64'(bus.ready), 64'd0);
                check($sformatf("rd_c%0d_we_n", c), 64'(sram_we_n), 64'd1);
            end
        end
        check("rd_c9_ready", 64'(bus.ready), 64'd1);
        check("rd_c9_rdata", bus.rdata, 64'hDEADBEEF_22221111);
        bus.r_en = 1'b0;
        tick();
        check("rd_idle_rdata", bus.rdata, 64'hDEADBEEF_22221111);

        // Both requests high: write wins, rdata untouched
        bus.address = 18'h00108;
        bus.wdata   = 32'h12345678;
        bus.r_en    = 1'b1;
        bus.w_en    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) check("both_c1_addr", 64'(sram_addr), 64'h84);
            if (c == 1) check("both_c1_dq", 64'(sram_dq), 64'h5678);
            if (c == 3) check("both_c3_addr", 64'(sram_addr), 64'h85);
            if (c == 4) check("both_c4_we_n", 64'(sram_we_n), 64'd0);
            if (c == 4) check("both_c4_ready", 64'(bus.ready), 64'd0);
        end
        check("both_c5_ready", 64'(bus.ready), 64'd1);
        check("both_c5_rdata", bus.rdata, 64'hDEADBEEF_22221111);
        bus.r_en = 1'b0;
        bus.w_en = 1'b0;
        tick();

        // Reset pulse during read beat 2, then a clean read
        bus.address = 18'h00104;
        bus.r_en    = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        check("rrst_c5_addr", 64'(sram_addr), 64'h82);
        #1 rst = 1'b1;
        #1;
        check("rrst_we_n", 64'(sram_we_n), 64'd1);
        check("rrst_rdata", bus.rdata, 64'd0);
        check("rrst_addr", 64'(sram_addr), 64'd0);
        check("rrst_dq_released", 64'(sram_dq), 64'hA5C3);
        bus.r_en = 1'b0;
        tick();
        rst = 1'b0;
        check("rrst_idle_ready", 64'(bus.ready), 64'd1);
        bus.r_en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 8) check("rrd_c8_ready", 64'(bus.ready), 64'd0);
        end
        check("rrd_c9_ready", 64'(bus.ready), 64'd1);
        check("rrd_c9_rdata", bus.rdata, 64'hDEADBEEF_22221111);

        // r_en held across DONE starts a second read right away
        bus.r_en = 1'b0;
        tick();
        bus.r_en = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 8)  check("hold_c8_ready", 64'(bus.ready), 64'd0);
            if (c == 9)  check("hold_c9_ready", 64'(bus.ready), 64'd1);
            if (c == 10) check("hold_c10_ready", 64'(bus.ready), 64'd0);
            if (c == 11) check("hold_c11_addr", 64'(sram_addr), 64'h80);
            if (c == 18) check("hold_c18_ready", 64'(bus.ready), 64'd0);
        end
        check("hold_c19_ready", 64'(bus.ready), 64'd1);
        check("hold_c19_rdata", bus.rdata, 64'hDEADBEEF_22221111);
        bus.r_en = 1'b0;
        tick();
        check("hold_idle_ready", 64'(bus.ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences the external 16-bit asynchronous SRAM on behalf of the data cache. It turns one cache-side request into a fixed sequence of halfword beats: a 64-bit line read (4 beats) or a 32-bit word write (2 beats). It sits between the cache controller and the board SRAM pins, and its `ready` handshake matches what the cache already expects.

## Interface
- `HOLD_CYCLES`, default 2: clock cycles each halfword beat is held on the SRAM pins. Legal range is ≥1.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `address`  in  18  byte address from the cache
- `wdata`  in  32  write word
- `r_en`  in  1  line-read request (level, held until `ready`)
- `w_en`  in  1  word-write request (level, held until `ready`)
- `rdata`  out  64  last completed line read
- `ready`  out  1  completion / idle indication
- `SRAM_DQ`  inout  16  SRAM data bus
- `SRAM_ADDR`  out  18  SRAM halfword address
- `SRAM_WE_N`  out  1  write enable, active-low
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied 0

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: requests are sampled only in this state.
  - `w_en` → WRITE (write wins if both requests are high; no read is performed).
  - else `r_en` → READ.
  - `address` and `wdata` are latched on the transition edge.
- READ: 4 beats, k = 0..3.
  - `SRAM_ADDR = {1'b0, addr[17:3], k[1:0]}`.
  - `SRAM_DQ` is Z.
  - The halfword is captured into shadow bits [16k+15:16k] on the last cycle of each beat.
  - On leaving READ the shadow is copied to `rdata` (little-endian halfword order).
- WRITE: 2 beats, k = 0..1.
  - `SRAM_ADDR = {1'b0, addr[17:2], k}`.
  - `SRAM_DQ` drives `wdata[16k+15:16k]`.
  - `SRAM_WE_N` = 0 for the whole beat.
- DONE: one cycle, then IDLE unconditionally.
- `ready = (IDLE & ~r_en & ~w_en) | DONE`. It is combinational.
- Requests dropped mid-access are ignored; the access completes and DONE still pulses.
- A request still high in the IDLE cycle after DONE starts a new access. The cache is responsible for deasserting its request after `ready`.
- `rdata` holds its value across writes and idle periods. It changes only at the end of a READ.

## Timing
- Cycle 0 is the IDLE cycle in which a request is high.
- READ occupies cycles 1..4·H. DONE/`ready`=1 in cycle 4·H+1, with `rdata` valid in the same cycle. H=2 gives cycle 9.
- WRITE occupies cycles 1..2·H. DONE in cycle 2·H+1. H=2 gives cycle 5.
- `ready`=0 from cycle 0 (request present in IDLE) until DONE.
- Beat counter and hold counter:
  - Widths: 2 bits for the beat, clog2(HOLD_CYCLES)+1 bits for the hold.
  - The beat advances when hold = HOLD_CYCLES−1.
  - The last beat exits to DONE.
- `SRAM_ADDR`, `SRAM_WE_N` and the DQ drive enable are registered outputs, so they are glitch-free. WE_N rises no later than the same edge at which ADDR changes.
- Reset values:
  - State IDLE, counters 0.
  - `rdata` = 0, `SRAM_ADDR` = 0, `SRAM_WE_N` = 1, DQ = Z.
  - `ready` = 1 when no request is present.
- Reset mid-access aborts immediately (asynchronous): WE_N goes high and DQ is released. Partial shadow data is discarded and `rdata` = 0.

## Structure
- Shared package/header `sram_defs`: state encodings; `READ_BEATS`=4, `WRITE_BEATS`=2; SRAM address and data widths.
- One natural sub-module, `sram_beat_counter`, which generates the hold/beat counts and a `last_beat` flag. Everything else lives in `sram_controller`.

## Test plan
- **Reset, no request:** expect `ready`=1, `SRAM_WE_N`=1, DQ=Z, `rdata`=0.
- **Write** `address`=18'h00104, `wdata`=32'hDEADBEEF:
  - `SRAM_ADDR` = 18'h00082 with DQ=16'hBEEF, then 18'h00083 with DQ=16'hDEAD.
  - WE_N low for 4 cycles; `ready` pulses in cycle 5.
- **Read** `address`=18'h00104 after the write above, with model halfwords 0x80=16'h1111 and 0x81=16'h2222:
  - `SRAM_ADDR` steps 0x80→0x83.
  - `rdata`=64'hDEADBEEF_22221111; `ready` in cycle 9.
- **`r_en` and `w_en` both high:** only the 2-beat write occurs, `ready` in cycle 5, and `rdata` is unchanged.
- **`rst` pulse during read beat 2:** WE_N=1, DQ=Z and `rdata`=0 immediately. A following read of 18'h00104 returns the correct line in 9 cycles.
- **`r_en` held high across DONE:** `ready` is high only in cycle 9, low in cycle 10, and a second read completes in cycle 19.
